// File: rtl/fpu_multicycle_sequencer.sv
// rtl/fpu_multicycle_sequencer.sv - sequences multi-cycle FP ops, stalls the core, hands the result to writeback
`ifndef FUNCT_W
`define FUNCT_W 5
`endif
`ifndef REG_W
`define REG_W 32
`endif
`ifndef FUNCT_FADD
`define FUNCT_FADD 5'h00
`endif
`ifndef FUNCT_FSUB
`define FUNCT_FSUB 5'h01
`endif
`ifndef FUNCT_FMUL
`define FUNCT_FMUL 5'h02
`endif
`ifndef FUNCT_FDIV
`define FUNCT_FDIV 5'h03
`endif

module fpu_multicycle_sequencer #(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 2,
    parameter int LAT_DIV = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_req,
    input  logic [`FUNCT_W-1:0] issue_funct,
    input  logic [`REG_W-1:0]   issue_op_s,
    input  logic [`REG_W-1:0]   issue_op_t,
    input  logic [4:0]          issue_dst,
    input  logic                kill,
    output logic [`REG_W-1:0]   unit_x1,
    output logic [`REG_W-1:0]   unit_x2,
    output logic [1:0]          unit_sel,
    input  logic [`REG_W-1:0]   fadd_y,
    input  logic [`REG_W-1:0]   fsub_y,
    input  logic [`REG_W-1:0]   fmul_y,
    input  logic [`REG_W-1:0]   fdiv_y,
    output logic                stall,
    output logic                wb_valid,
    input  logic                wb_ready,
    output logic [4:0]          wb_dst,
    output logic [`REG_W-1:0]   wb_data
);
    if (LAT_ADD < 1 || LAT_ADD > 16) begin : g_bad_lat_add
        $error("LAT_ADD must be in 1..16");
    end
    if (LAT_MUL < 1 || LAT_MUL > 16) begin : g_bad_lat_mul
        $error("LAT_MUL must be in 1..16");
    end
    if (LAT_DIV < 1 || LAT_DIV > 16) begin : g_bad_lat_div
        $error("LAT_DIV must be in 1..16");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [`REG_W-1:0] x1_q, x1_d, x2_q, x2_d, wb_data_q, wb_data_d;
    logic [1:0]        sel_q, sel_d;
    logic [4:0]        wb_dst_q, wb_dst_d;
    logic              wb_valid_q, wb_valid_d;

    logic              mc;
    logic [1:0]        issue_sel;
    logic [3:0]        issue_cnt;
    logic [`REG_W-1:0] unit_y;

    always_comb begin
        mc        = issue_req;
        issue_sel = 2'd0;
        case (issue_funct)
            `FUNCT_FADD: issue_sel = 2'd0;
            `FUNCT_FSUB: issue_sel = 2'd1;
            `FUNCT_FMUL: issue_sel = 2'd2;
            `FUNCT_FDIV: issue_sel = 2'd3;
            default:     mc = 1'b0;
        endcase
        case (issue_sel)
            2'd0, 2'd1: issue_cnt = 4'(LAT_ADD - 1);
            2'd2:       issue_cnt = 4'(LAT_MUL - 1);
            default:    issue_cnt = 4'(LAT_DIV - 1);
        endcase
        case (sel_q)
            2'd0:    unit_y = fadd_y;
            2'd1:    unit_y = fsub_y;
            2'd2:    unit_y = fmul_y;
            default: unit_y = fdiv_y;
        endcase
    end

    // kill overrides everything, including a coincident handshake
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        sel_d      = sel_q;
        wb_dst_d   = wb_dst_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = wb_valid_q;
        if (kill) begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (mc) begin
                    x1_d     = issue_op_s;
                    x2_d     = issue_op_t;
                    sel_d    = issue_sel;
                    wb_dst_d = issue_dst;
                    cnt_d    = issue_cnt;
                    state_d  = ST_BUSY;
                end
                ST_BUSY: if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    wb_data_d  = unit_y;
                    wb_valid_d = 1'b1;
                    state_d    = ST_DONE;
                end
                ST_DONE: if (wb_ready) begin
                    wb_valid_d = 1'b0;
                    state_d    = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign stall = !kill && ((state_q == ST_IDLE && mc) || state_q == ST_BUSY ||
                             (state_q == ST_DONE && !wb_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            x1_q       <= '0;
            x2_q       <= '0;
            sel_q      <= 2'd0;
            wb_dst_q   <= 5'd0;
            wb_data_q  <= '0;
            wb_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            sel_q      <= sel_d;
            wb_dst_q   <= wb_dst_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
        end
    end

    assign unit_x1  = x1_q;
    assign unit_x2  = x2_q;
    assign unit_sel = sel_q;
    assign wb_dst   = wb_dst_q;
    assign wb_data  = wb_data_q;
    assign wb_valid = wb_valid_q;
endmodule
